mmbmp_fetch: RTL and testbench

//   Pipelined memory-mapped bitmap pixel fetch unit for the scan-out path.

---
 rtl/mmbmp_fetch.sv | 123 ++++++++++++
 tb/tb_mmbmp_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmbmp_fetch.sv
// Bitmap scan-out fetch: raster position -> screen-RAM read address -> 4-bit pixel stream.
// Latency: inputs sampled at edge k give scr_addr/scr_rd after edge k and m_pixel/pixel_valid after edge k+1.
// Backpressure: none; the pipeline advances every pixel clock and the RAM must answer in one cycle.
module mmbmp_fetch #(
    parameter int ADDR_W       = 16,
    parameter int H_SCALE_LOG2 = 1,
    parameter int V_SCALE_LOG2 = 1,
    parameter int STRIDE_LOG2  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        posx,
    input  logic [8:0]        posy,
    input  logic              de,
    input  logic              frame_start,
    input  logic [1:0]        mode_in,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [7:0]        val,
    output logic [ADDR_W-1:0] scr_addr,
    output logic              scr_rd,
    output logic [3:0]        m_pixel,
    output logic              pixel_valid
);

    // Per-pixel side information carried from the address stage to the output stage.
    typedef struct packed {
        logic       de;
        logic [2:0] idx;
        logic [1:0] mode;
    } pipe_t;

    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        byte_latch;
    // Set while scr_addr names a byte that has been (or is being) fetched this run of de.
    logic              latch_vld;
    pipe_t             pipe_q;

    logic [9:0]        col;
    logic [8:0]        row;
    logic [9:0]        byte_off;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        idx;
    logic              rd_nxt;

    logic [7:0]        src_byte;
    logic [1:0]        field2;
    logic [3:0]        pix_nxt;

    // Stage 0: scaled raster position to byte address, pixel index and fetch decision.
    always_comb begin
        col      = posx >> H_SCALE_LOG2;
        row      = posy >> V_SCALE_LOG2;
        byte_off = col >> (2'd3 - mode_q);
        addr     = base_q + (ADDR_W'(row) << (STRIDE_LOG2 + int'(mode_q))) + ADDR_W'(byte_off);
        case (mode_q)
            2'd0:    idx = col[2:0];
            2'd1:    idx = {1'b0, col[1:0]};
            2'd2:    idx = {2'b00, col[0]};
            default: idx = 3'd0;
        endcase
        rd_nxt = de && (!latch_vld || (addr != scr_addr));
    end

    // Frame shadows: mode and base only change on a frame_start edge so a frame is self-consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'd0;
            base_q <= '0;
        end else if (frame_start) begin
            mode_q <= mode_in;
            base_q <= base_in;
        end
    end

    // Stage 0 registers: RAM address/strobe plus the side information for the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_addr  <= '0;
            scr_rd    <= 1'b0;
            latch_vld <= 1'b0;
            pipe_q    <= '0;
        end else begin
            scr_rd    <= rd_nxt;
            latch_vld <= de;
            if (de) begin
                scr_addr <= addr;
            end
            pipe_q.de   <= de;
            pipe_q.idx  <= idx;
            pipe_q.mode <= mode_q;
        end
    end

    // Stage 1: pick fresh RAM data when a read was issued, otherwise reuse the held byte, then expand.
    always_comb begin
        src_byte = scr_rd ? val : byte_latch;
        field2   = src_byte[{pipe_q.idx[1:0], 1'b0} +: 2];
        pix_nxt  = 4'd0;
        case (pipe_q.mode)
            2'd0:    pix_nxt = {4{src_byte[pipe_q.idx]}};
            2'd1:    pix_nxt = {field2, field2};
            2'd2:    pix_nxt = src_byte[{pipe_q.idx[0], 2'b00} +: 4];
            default: pix_nxt = src_byte[7:4];
        endcase
    end

    // Stage 1 registers: byte latch for redundant-read suppression and the pixel output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_latch  <= 8'd0;
            m_pixel     <= 4'd0;
            pixel_valid <= 1'b0;
        end else begin
            if (scr_rd) begin
                byte_latch <= val;
            end
            m_pixel     <= pipe_q.de ? pix_nxt : 4'd0;
            pixel_valid <= pipe_q.de;
        end
    end

endmodule

// File: tb/tb_mmbmp_fetch.sv
// Directed bench for mmbmp_fetch with a reference model and pixel scoreboard.
// Latency: model predicts scr_rd/scr_addr one edge after drive and pixels one edge later.
// Backpressure: none; the bench drives one raster position per clock.
module tb_mmbmp_fetch;

    logic        clk;
    logic        rst_n;
    logic [9:0]  posx;
    logic [8:0]  posy;
    logic        de;
    logic        frame_start;
    logic [1:0]  mode_in;
    logic [15:0] base_in;
    logic [7:0]  val;
    logic [15:0] scr_addr;
    logic        scr_rd;
    logic [3:0]  m_pixel;
    logic        pixel_valid;

    mmbmp_fetch #(
        .ADDR_W      (16),
        .H_SCALE_LOG2(1),
        .V_SCALE_LOG2(1),
        .STRIDE_LOG2 (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .posx       (posx),
        .posy       (posy),
        .de         (de),
        .frame_start(frame_start),
        .mode_in    (mode_in),
        .base_in    (base_in),
        .val        (val),
        .scr_addr   (scr_addr),
        .scr_rd     (scr_rd),
        .m_pixel    (m_pixel),
        .pixel_valid(pixel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [1:0]  sh_mode;
    logic [15:0] sh_base;
    logic [15:0] last_rd_addr;
    logic        last_vld;
    logic [15:0] exp_addr;
    logic [7:0]  lat_byte;
    logic [7:0]  ram_val;
    logic [4:0]  sb[$];
    logic [63:0] pix_log;
    int          rd_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_addr(input logic [9:0] x, input logic [8:0] y,
                                               input logic [1:0] m, input logic [15:0] b);
        int c;
        int r;
        int ppb;
        c   = int'(x) / 2;
        r   = int'(y) / 2;
        ppb = 8 >> m;
        return 16'(int'(b) + r * (64 << m) + c / ppb);
    endfunction

    function automatic logic [2:0] model_idx(input logic [9:0] x, input logic [1:0] m);
        int c;
        c = int'(x) / 2;
        return 3'(c % (8 >> m));
    endfunction

    function automatic logic [3:0] expand(input logic [7:0] b, input logic [1:0] m, input logic [2:0] ix);
        int bpp;
        int f;
        bpp = 1 << m;
        f   = (int'(b) >> (int'(ix) * bpp)) & ((1 << bpp) - 1);
        case (m)
            2'd0:    return (f != 0) ? 4'hF : 4'h0;
            2'd1:    return 4'(f * 5);
            2'd2:    return 4'(f);
            default: return b[7:4];
        endcase
    endfunction

    task automatic model_reset();
        sh_mode      = 2'd0;
        sh_base      = 16'd0;
        last_rd_addr = 16'd0;
        last_vld     = 1'b0;
        exp_addr     = 16'd0;
        lat_byte     = 8'd0;
        sb.delete();
        sb.push_back(5'd0);
    endtask

    // One raster position per clock: predict, clock, compare, then present RAM data for the next edge.
    task automatic step(input logic [9:0] x, input logic [8:0] y, input logic d, input logic fs);
        logic [15:0] a;
        logic [2:0]  ix;
        logic        r;
        logic [7:0]  b;
        logic [4:0]  e;
        logic [4:0]  got;
        posx        = x;
        posy        = y;
        de          = d;
        frame_start = fs;
        a  = model_addr(x, y, sh_mode, sh_base);
        ix = model_idx(x, sh_mode);
        r  = d && (!last_vld || (a != last_rd_addr));
        if (d) exp_addr = a;
        b  = r ? ram_val : lat_byte;
        e  = d ? {1'b1, expand(b, sh_mode, ix)} : 5'd0;
        @(posedge clk);
        #1;
        check("scr_rd", 64'(scr_rd), 64'(r));
        check("scr_addr", 64'(scr_addr), 64'(exp_addr));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            got = 5'd0;
        end else begin
            got = sb.pop_front();
        end
        check("pixel_valid", 64'(pixel_valid), 64'(got[4]));
        check("m_pixel", 64'(m_pixel), 64'(got[3:0]));
        if (pixel_valid) pix_log = {pix_log[59:0], m_pixel};
        if (scr_rd) rd_count++;
        sb.push_back(e);
        val = r ? ram_val : ~ram_val;
        if (r) begin
            lat_byte     = ram_val;
            last_rd_addr = a;
        end
        last_vld = d;
        if (fs) begin
            sh_mode = mode_in;
            sh_base = base_in;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        posx        = 10'd0;
        posy        = 9'd0;
        de          = 1'b0;
        frame_start = 1'b0;
        mode_in     = 2'd0;
        base_in     = 16'd0;
        val         = 8'd0;
        ram_val     = 8'd0;
        pix_log     = 64'd0;
        rd_count    = 0;
        model_reset();

        // Reset state
        #12;
        check("rst_scr_addr", 64'(scr_addr), 64'd0);
        check("rst_scr_rd", 64'(scr_rd), 64'd0);
        check("rst_m_pixel", 64'(m_pixel), 64'd0);
        check("rst_pixel_valid", 64'(pixel_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1bpp, base 0, one byte covers 16 scaled positions
        mode_in = 2'd0; base_in = 16'h0000; ram_val = 8'hA5;
        step(10'd0, 9'd0, 1'b0, 1'b1);
        pix_log = 64'd0; rd_count = 0;
        for (int i = 0; i < 16; i++) begin
            step(10'(i), 9'd0, 1'b1, 1'b0);
            if (i == 15) check("t1_addr", 64'(scr_addr), 64'h0000);
        end
        step(10'd0, 9'd0, 1'b0, 1'b0);
        step(10'd0, 9'd0, 1'b0, 1'b0);
        check("t1_rd_count", 64'(rd_count), 64'd1);
        check("t1_pixels", pix_log, 64'hFF00_FF00_00FF_00FF);

        // 4bpp addressing and nibble select
        mode_in = 2'd2; base_in = 16'h1000; ram_val = 8'h3C;
        step(10'd0, 9'd0, 1'b0, 1'b1);
        step(10'd20, 9'd6, 1'b1, 1'b0);
        check("t2_addr", 64'(scr_addr), 64'h1305);
        step(10'd0, 9'd0, 1'b0, 1'b0);
        check("t2_pixel", 64'(m_pixel), 64'hC);

        // Mode change without frame_start is ignored until the next frame_start
        mode_in = 2'd1; base_in = 16'h0000; ram_val = 8'hB4;
        step(10'd0, 9'd0, 1'b0, 1'b1);
        mode_in = 2'd3;
        for (int i = 0; i < 6; i++) begin
            step(10'(i), 9'd2, 1'b1, 1'b0);
            if (i == 4) check("t3_addr_2bpp", 64'(scr_addr), 64'h0080);
        end
        step(10'd0, 9'd0, 1'b0, 1'b1);
        step(10'd6, 9'd2, 1'b1, 1'b0);
        check("t3_addr_8bpp", 64'(scr_addr), 64'h0203);
        step(10'd0, 9'd0, 1'b0, 1'b0);
        check("t3_pixel_8bpp", 64'(m_pixel), 64'hB);

        // de gap inside one byte forces a second read of the same address
        mode_in = 2'd0; base_in = 16'h0400; ram_val = 8'h5A;
        step(10'd0, 9'd0, 1'b0, 1'b1);
        rd_count = 0;
        step(10'd0, 9'd4, 1'b1, 1'b0);
        step(10'd2, 9'd4, 1'b0, 1'b0);
        step(10'd4, 9'd4, 1'b1, 1'b0);
        check("t4_second_rd", 64'(scr_rd), 64'd1);
        check("t4_blank_valid", 64'(pixel_valid), 64'd0);
        check("t4_blank_pixel", 64'(m_pixel), 64'd0);
        step(10'd0, 9'd0, 1'b0, 1'b0);
        step(10'd0, 9'd0, 1'b0, 1'b0);
        check("t4_rd_count", 64'(rd_count), 64'd2);

        // Back-to-back frame_start (last wins) and address wrap
        ram_val = 8'h81;
        mode_in = 2'd2; base_in = 16'h1234;
        step(10'd0, 9'd0, 1'b0, 1'b1);
        mode_in = 2'd0; base_in = 16'hFFF0;
        step(10'd0, 9'd0, 1'b0, 1'b1);
        mode_in = 2'd3; base_in = 16'h5555;
        step(10'd512, 9'd0, 1'b1, 1'b0);
        check("t5_wrap_addr", 64'(scr_addr), 64'h0010);
        step(10'd514, 9'd1, 1'b1, 1'b0);
        step(10'd0, 9'd0, 1'b0, 1'b0);
        step(10'd0, 9'd0, 1'b0, 1'b0);

        // Reset mid-line: asynchronous clear and refetch of the same address afterwards
        mode_in = 2'd0; base_in = 16'h0000; ram_val = 8'h0F;
        step(10'd0, 9'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(10'(i), 9'd0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_addr", 64'(scr_addr), 64'd0);
        check("t6_async_rd", 64'(scr_rd), 64'd0);
        check("t6_async_pixel", 64'(m_pixel), 64'd0);
        check("t6_async_valid", 64'(pixel_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(10'd4, 9'd0, 1'b1, 1'b0);
        check("t6_first_rd", 64'(scr_rd), 64'd1);
        step(10'd5, 9'd0, 1'b1, 1'b0);
        step(10'd0, 9'd0, 1'b0, 1'b0);
        step(10'd0, 9'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
